// File: rtl/prog_loader.sv
// Boot-time program loader: assembles header/word/checksum byte stream into
// 32-bit program memory writes and enables the core only after a verified load.
//
// state | meaning
// IDLE  | after reset, waiting for start
// HDR   | accepting the word-count byte
// DATA  | accepting 4N little-endian instruction bytes
// CSUM  | accepting the checksum byte and deciding RUN/ERR
// RUN   | verified program, core enabled
// ERR   | checksum mismatch, core held off
module prog_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic              cpu_run,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    RUN  = 3'd4,
    ERR  = 3'd5
  } state_t;

  state_t            state;
  logic [1:0]        lane;
  logic [8:0]        words_rem;
  logic [ADDR_W-1:0] word_idx;
  logic [7:0]        csum;
  logic [23:0]       data_buf;

  logic xfer;
  assign xfer = rx_valid && rx_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lane      <= 2'd0;
      words_rem <= 9'd0;
      word_idx  <= '0;
      csum      <= 8'd0;
      data_buf  <= 24'd0;
      rx_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= 32'd0;
      cpu_run   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE, RUN, ERR: begin
          if (start) begin
            state    <= HDR;
            rx_ready <= 1'b1;
            busy     <= 1'b1;
            cpu_run  <= 1'b0;
            err      <= 1'b0;
            word_idx <= '0;
            csum     <= 8'd0;
            lane     <= 2'd0;
          end
        end
        HDR: begin
          if (xfer) begin
            words_rem <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
            lane      <= 2'd0;
            state     <= DATA;
          end
        end
        DATA: begin
          if (xfer) begin
            csum <= csum ^ rx_data;
            lane <= lane + 2'd1;
            // Bytes shift in from the top so the first byte ends up in [7:0].
            if (lane == 2'd3) begin
              mem_we    <= 1'b1;
              mem_din   <= {rx_data, data_buf};
              mem_addr  <= word_idx;
              word_idx  <= word_idx + 1'b1;
              words_rem <= words_rem - 9'd1;
              if (words_rem == 9'd1)
                state <= CSUM;
            end else begin
              data_buf <= {rx_data, data_buf[23:8]};
            end
          end
        end
        CSUM: begin
          if (xfer) begin
            rx_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            if (rx_data == csum) begin
              state   <= RUN;
              cpu_run <= 1'b1;
            end else begin
              state <= ERR;
              err   <= 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          rx_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized scoreboard bench for prog_loader: expected writes and load
// outcomes are queued by a stream-level model and popped by a monitor.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_din;
  logic        cpu_run;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [39:0] exp_w[$];
  logic [1:0]  exp_r[$];
  logic [7:0]  stream[$];
  logic        loading = 1'b0;

  prog_loader #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .cpu_run(cpu_run), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a write or a decision.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we) begin
        if (exp_w.size() == 0) chk("unexpected_write", {24'd0, mem_addr, mem_din}, 64'hDEAD);
        else begin
          logic [39:0] e;
          e = exp_w.pop_front();
          chk("write_addr", {56'd0, mem_addr}, {56'd0, e[39:32]});
          chk("write_data", {32'd0, mem_din}, {32'd0, e[31:0]});
        end
      end
      if (done) begin
        if (exp_r.size() == 0) chk("unexpected_done", {62'd0, cpu_run, err}, 64'hDEAD);
        else begin
          logic [1:0] r;
          r = exp_r.pop_front();
          chk("decision_run_err", {62'd0, cpu_run, err}, {62'd0, r});
        end
      end
      if (loading) chk("busy_during_load", {63'd0, busy}, 64'd1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int maxgap, input bit st);
    int n;
    int gap;
    gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
    rx_valid = 1'b0;
    repeat (gap) tick();
    rx_valid = 1'b1;
    rx_data  = b;
    start    = st;
    n = 0;
    while (!rx_ready && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) chk("rx_ready_timeout", 64'd0, 64'd1);
    tick();
    rx_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rx_ready_after_start", {63'd0, rx_ready}, 64'd1);
    chk("cpu_run_after_start", {63'd0, cpu_run}, 64'd0);
  endtask

  // Expected results derived from the stream itself: word k packs bytes 4k..4k+3
  // with the first byte lowest; the checksum is the XOR of every data byte.
  task automatic run_load(input int n_hdr, input bit bad_csum, input int maxgap, input int start_idx);
    int nw;
    logic [7:0] x;
    logic [7:0] cs;
    nw = (n_hdr == 0) ? 256 : n_hdr;
    x = 8'd0;
    for (int k = 0; k < nw; k++) begin
      logic [7:0] a;
      a = k[7:0];
      exp_w.push_back({a, stream[4*k+3], stream[4*k+2], stream[4*k+1], stream[4*k]});
      for (int j = 0; j < 4; j++) x = x ^ stream[4*k+j];
    end
    cs = bad_csum ? (x ^ 8'h01) : x;
    exp_r.push_back(bad_csum ? 2'b01 : 2'b10);
    do_start();
    loading = 1'b1;
    send_byte(n_hdr[7:0], maxgap, 1'b0);
    for (int i = 0; i < 4*nw; i++) send_byte(stream[i], maxgap, i == start_idx);
    send_byte(cs, maxgap, 1'b0);
    loading = 1'b0;
    chk("done_after_csum", {63'd0, done}, 64'd1);
    repeat (3) tick();
    chk("writes_drained", {32'd0, exp_w.size()}, 64'd0);
    chk("decision_drained", {32'd0, exp_r.size()}, 64'd0);
    chk("cpu_run_level", {63'd0, cpu_run}, {63'd0, !bad_csum});
    chk("err_level", {63'd0, err}, {63'd0, bad_csum});
  endtask

  task automatic fill_random(input int nw);
    stream.delete();
    for (int i = 0; i < 4*nw; i++) stream.push_back(8'($urandom));
  endtask

  initial begin
    repeat (2) tick();
    chk("reset_outputs", {56'd0, rx_ready, mem_we, cpu_run, busy, done, err, 2'b00}, 64'd0);
    chk("reset_addr_din", {24'd0, mem_addr, mem_din}, 64'd0);
    rst = 1'b0;
    tick();

    // Single word, good then bad checksum, then recover.
    stream = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_load(1, 1'b0, 0, -1);
    run_load(1, 1'b1, 0, -1);
    chk("restart_from_err_cpu_run", {63'd0, cpu_run}, 64'd0);
    run_load(1, 1'b0, 0, -1);

    // Full depth.
    stream.delete();
    for (int k = 0; k < 256; k++) repeat (4) stream.push_back(k[7:0]);
    run_load(0, 1'b0, 0, -1);

    // Back-pressure with N=2, and start pulsed during DATA.
    fill_random(2);
    run_load(2, 1'b0, 5, -1);
    run_load(2, 1'b0, 5, 3);

    // Reset mid-load after 3 data bytes.
    do_start();
    loading = 1'b1;
    send_byte(8'd2, 0, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(8'hA0 + 8'(i), 0, 1'b0);
    loading = 1'b0;
    rst = 1'b1;
    #1;
    chk("midload_reset_outputs", {56'd0, rx_ready, mem_we, cpu_run, busy, done, err, 2'b00}, 64'd0);
    chk("midload_reset_addr_din", {24'd0, mem_addr, mem_din}, 64'd0);
    tick();
    rst = 1'b0;
    tick();
    fill_random(1);
    run_load(1, 1'b0, 0, -1);

    // Random loads; first start here is a restart from RUN or ERR.
    for (int t = 0; t < 6; t++) begin
      int n;
      n = int'($urandom_range(8, 1));
      fill_random(n);
      run_load(n, bit'($urandom_range(1, 0)), int'($urandom_range(3, 0)), int'($urandom_range(4*n+3, 0)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader and run controller for the 8-bit soft processor. Receives a byte stream (header, instruction words, checksum), assembles 32-bit instructions and writes them into the 256-entry program memory via its write port. On a good checksum it asserts cpu_run, which gates the processor's clock enable. While loading or on error, cpu_run is held low so the core never fetches a partially written program.

## Interface
- ADDR_W, 8, program memory address width; fixed at 8 for the 256-word program memory.
- clk  in  1  system clock; same clock as the program memory write port.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a load; honoured only in IDLE, RUN or ERR.
- rx_data  in  8  incoming stream byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  loader accepts a byte; a transfer occurs on a rising edge with rx_valid && rx_ready.
- mem_we  out  1  program memory write enable; one-cycle pulse per word.
- mem_addr  out  ADDR_W  program memory word address.
- mem_din  out  32  instruction word to write.
- cpu_run  out  1  processor enable; high only after a verified load.
- busy  out  1  high in HDR, DATA and CSUM.
- done  out  1  one-cycle pulse on entry to RUN or ERR.
- err  out  1  checksum mismatch; level, held in ERR.

## Operation
- States:
  - IDLE: entered on reset. start -> HDR.
  - HDR: accepts 1 byte, the word count N. N=0 means 256 words. -> DATA.
  - DATA: accepts 4N bytes, little-endian, so the first byte goes to [7:0].
  - CSUM: accepts 1 byte and compares it with the XOR of all 4N data bytes (header excluded). Match -> RUN; mismatch -> ERR.
  - RUN: cpu_run=1.
  - ERR: err=1, cpu_run=0.
  - From RUN or ERR, start -> HDR: cpu_run and err clear, word index clears, checksum accumulator clears.
- start is ignored in HDR, DATA and CSUM.
- rx_ready = 1 in HDR, DATA and CSUM, and 0 otherwise. Loading never stalls on memory writes.
- Counters:
  - 2-bit byte lane.
  - 9-bit words-remaining counter, loaded with (N==0 ? 256 : N).
  - 8-bit word index, starting at 0 and incrementing after each write. It wraps 255->0 only after the final word of N=0; that value is unused.
- Checksum accumulator: 8-bit, XOR of data bytes, cleared on entering HDR.
- mem_addr and mem_din are registered and held stable from the write pulse until the next write.
- Reset mid-load: immediate return to IDLE with all outputs 0. Memory contents are undefined until the next complete load.

## Timing
- Reset values: rx_ready=0, mem_we=0, mem_addr=0, mem_din=0, cpu_run=0, busy=0, done=0, err=0.
- IDLE->HDR: the cycle after start is sampled. rx_ready rises in that same cycle.
- Write latency:
  - mem_we is high in the cycle after the 4th byte of a word is accepted, for exactly 1 cycle.
  - mem_addr and mem_din are valid in that cycle.
  - Back-to-back words at full rate give one write every 4 cycles.
- The checksum byte may be accepted in the same cycle as the final mem_we.
- Decision timing: cpu_run (or err) and done go high the cycle after the checksum byte is accepted. That is no earlier than 1 cycle after the last write.
- rx_valid gaps of any length are legal. State and counters hold while rx_valid=0.
- Restart from RUN: cpu_run drops in the same cycle busy rises, which is the cycle after start.

## Test plan
- Single word: start; bytes 0x01, 0x11, 0x22, 0x33, 0x44, 0x44 at full rate.
  - Expected: one mem_we with addr 0x00, din 0x44332211; then cpu_run=1, done pulse, err=0.
- Bad checksum: same stream with checksum 0x45.
  - Expected: the write still occurs; err=1, cpu_run=0, done pulse.
  - Then start plus the valid stream -> err clears and cpu_run=1.
- Full depth: N=0x00, 1024 bytes where word k = {k, k, k, k}, followed by the correct checksum.
  - Expected: 256 writes at addresses 0..255 in order, then RUN.
- Back-pressure: N=2 with random rx_valid gaps of 0-5 cycles.
  - Expected: the same writes and data as gap-free, no dropped or duplicated bytes, and busy high throughout.
- Reset mid-load: assert rst after 3 data bytes.
  - Expected: all outputs 0 immediately.
  - A fresh start then loads correctly, with the word index beginning at 0.
- start while busy: pulse start during DATA.
  - Expected: ignored, with the load completing unchanged. Restart from RUN drops cpu_run the cycle after start.
